// File: rtl/ifu_jalr_btb.sv
// ifu_jalr_btb: direct-mapped branch target buffer for JALR predictions.
// Registered lookup (1-cycle latency), update port from the EXU branch unit,
// and whole-table flush. Same-cycle update/lookup to one index bypasses the
// new entry into the lookup result.
// Optional feature macro: BTB_HYST_EN adds a 2-bit confidence counter per
// entry so a single mispredicting target does not immediately evict a
// stable one.
module ifu_jalr_btb #(
  parameter int BTB_ENTRIES = 16,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lookup_req_i,
  input  logic [ADDR_W-1:0] lookup_pc_i,
  output logic              pred_valid_o,
  output logic              pred_hit_o,
  output logic [ADDR_W-1:0] pred_pc_o,
  output logic [ADDR_W-1:0] pred_target_o,
  input  logic              update_i,
  input  logic [ADDR_W-1:0] update_pc_i,
  input  logic [ADDR_W-1:0] update_target_i,
  input  logic              flush_i
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  logic [BTB_ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]       tag_q [BTB_ENTRIES];
  logic [ADDR_W-1:0]      tgt_q [BTB_ENTRIES];
`ifdef BTB_HYST_EN
  logic [1:0]             ctr_q [BTB_ENTRIES];
  logic [1:0]             new_ctr;
`endif

  logic [IDX_W-1:0]  lk_idx, up_idx;
  logic [TAG_W-1:0]  lk_tag, up_tag;
  logic              up_wr;
  logic              up_hit;
  logic [ADDR_W-1:0] new_tgt;
  logic              lk_hit;
  logic [ADDR_W-1:0] lk_tgt;

  // Index/tag extraction; pc[1:0] never participates.
  always_comb begin
    lk_idx = lookup_pc_i[IDX_W+1:2];
    lk_tag = lookup_pc_i[ADDR_W-1:IDX_W+2];
    up_idx = update_pc_i[IDX_W+1:2];
    up_tag = update_pc_i[ADDR_W-1:IDX_W+2];
    // Flush in the same cycle discards the update entirely.
    up_wr  = update_i && !flush_i;
    up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  end

  // Contents the updated entry will hold after this edge.
`ifdef BTB_HYST_EN
  always_comb begin
    new_tgt = update_target_i;
    new_ctr = 2'd1;
    if (up_hit) begin
      if (tgt_q[up_idx] == update_target_i) begin
        new_tgt = tgt_q[up_idx];
        new_ctr = (ctr_q[up_idx] == 2'd3) ? 2'd3 : ctr_q[up_idx] + 2'd1;
      end else if (ctr_q[up_idx] != 2'd0) begin
        new_tgt = tgt_q[up_idx];
        new_ctr = ctr_q[up_idx] - 2'd1;
      end
    end
  end
`else
  always_comb begin
    new_tgt = update_target_i;
  end
`endif

  // Lookup result with write-first bypass; flush forces a miss.
  always_comb begin
    lk_hit = 1'b0;
    lk_tgt = '0;
    if (flush_i) begin
      lk_hit = 1'b0;
    end else if (up_wr && (up_idx == lk_idx)) begin
      lk_hit = (up_tag == lk_tag);
      lk_tgt = new_tgt;
    end else begin
      lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
      lk_tgt = tgt_q[lk_idx];
    end
  end

  // Valid bits: reset and flush clear the whole table.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      valid_q <= '0;
    end else if (up_wr) begin
      valid_q[up_idx] <= 1'b1;
    end
  end

  // Tag/target storage is not reset; valid bits gate its use.
  always_ff @(posedge clk) begin
    if (!rst && up_wr) begin
      tag_q[up_idx] <= up_tag;
      tgt_q[up_idx] <= new_tgt;
`ifdef BTB_HYST_EN
      ctr_q[up_idx] <= new_ctr;
`endif
    end
  end

  // Prediction output register; pc/target hold when no lookup.
  always_ff @(posedge clk) begin
    if (rst) begin
      pred_valid_o  <= 1'b0;
      pred_hit_o    <= 1'b0;
      pred_pc_o     <= '0;
      pred_target_o <= '0;
    end else begin
      pred_valid_o <= lookup_req_i;
      pred_hit_o   <= lookup_req_i && lk_hit;
      if (lookup_req_i) begin
        pred_pc_o     <= lookup_pc_i;
        pred_target_o <= lk_hit ? lk_tgt : '0;
      end
    end
  end

endmodule

// File: tb/tb_ifu_jalr_btb.sv
// Directed testbench for ifu_jalr_btb (BTB_ENTRIES=16, ADDR_W=32).
// Expected values follow BTB_HYST_EN when the bench is built with it.
module tb_ifu_jalr_btb;

  logic        clk = 1'b0;
  logic        rst;
  logic        lookup_req_i;
  logic [31:0] lookup_pc_i;
  logic        pred_valid_o;
  logic        pred_hit_o;
  logic [31:0] pred_pc_o;
  logic [31:0] pred_target_o;
  logic        update_i;
  logic [31:0] update_pc_i;
  logic [31:0] update_target_i;
  logic        flush_i;

  int checks   = 0;
  int failures = 0;

  ifu_jalr_btb #(.BTB_ENTRIES(16), .ADDR_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .lookup_req_i    (lookup_req_i),
    .lookup_pc_i     (lookup_pc_i),
    .pred_valid_o    (pred_valid_o),
    .pred_hit_o      (pred_hit_o),
    .pred_pc_o       (pred_pc_o),
    .pred_target_o   (pred_target_o),
    .update_i        (update_i),
    .update_pc_i     (update_pc_i),
    .update_target_i (update_target_i),
    .flush_i         (flush_i)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    lookup_req_i = 1'b0;
    update_i     = 1'b0;
    flush_i      = 1'b0;
  endtask

  // Single-cycle lookup, then sample the registered result.
  task automatic lookup(input logic [31:0] pc);
    idle();
    lookup_req_i = 1'b1;
    lookup_pc_i  = pc;
    tick();
    idle();
  endtask

  task automatic update(input logic [31:0] pc, input logic [31:0] tgt);
    idle();
    update_i        = 1'b1;
    update_pc_i     = pc;
    update_target_i = tgt;
    tick();
    idle();
  endtask

  logic [31:0] exp_t3;
  logic [31:0] exp_t6;

  initial begin
    rst             = 1'b1;
    lookup_req_i    = 1'b0;
    lookup_pc_i     = '0;
    update_i        = 1'b0;
    update_pc_i     = '0;
    update_target_i = '0;
    flush_i         = 1'b0;
`ifdef BTB_HYST_EN
    exp_t3 = 32'h8000_0200;
    exp_t6 = 32'h0000_1000;
`else
    exp_t3 = 32'h8000_0300;
    exp_t6 = 32'h0000_2000;
`endif
    tick();
    tick();
    chk("rst_valid",  {31'd0, pred_valid_o}, 32'd0);
    chk("rst_hit",    {31'd0, pred_hit_o},   32'd0);
    chk("rst_pc",     pred_pc_o,             32'd0);
    chk("rst_target", pred_target_o,         32'd0);
    rst = 1'b0;

    // T1 cold miss
    lookup(32'h8000_0010);
    chk("t1_valid",  {31'd0, pred_valid_o}, 32'd1);
    chk("t1_hit",    {31'd0, pred_hit_o},   32'd0);
    chk("t1_pc",     pred_pc_o,             32'h8000_0010);
    chk("t1_target", pred_target_o,         32'd0);

    // T2 allocate, hit, alias miss; idle cycle holds pc
    update(32'h8000_0010, 32'h8000_0200);
    chk("t2_idle_valid", {31'd0, pred_valid_o}, 32'd0);
    chk("t2_idle_pc",    pred_pc_o,             32'h8000_0010);
    lookup(32'h8000_0010);
    chk("t2_hit",    {31'd0, pred_hit_o}, 32'd1);
    chk("t2_target", pred_target_o,       32'h8000_0200);
    update(32'h8000_0020, 32'h8000_0400);
    lookup(32'h8000_0010);
    chk("t2_other_idx_target", pred_target_o, 32'h8000_0200);
    lookup(32'h8000_0020);
    chk("t2_idx8_target", pred_target_o, 32'h8000_0400);
    lookup(32'h8000_0050);
    chk("t2_alias_valid",  {31'd0, pred_valid_o}, 32'd1);
    chk("t2_alias_hit",    {31'd0, pred_hit_o},   32'd0);
    chk("t2_alias_target", pred_target_o,         32'd0);

    // T3 bypass: same-tag update, then conflicting-tag overwrite
    lookup_req_i    = 1'b1;
    lookup_pc_i     = 32'h8000_0010;
    update_i        = 1'b1;
    update_pc_i     = 32'h8000_0010;
    update_target_i = 32'h8000_0300;
    tick();
    idle();
    chk("t3_byp_hit",    {31'd0, pred_hit_o}, 32'd1);
    chk("t3_byp_target", pred_target_o,       exp_t3);
    lookup_req_i    = 1'b1;
    lookup_pc_i     = 32'h8000_0050;
    update_i        = 1'b1;
    update_pc_i     = 32'h8000_0050;
    update_target_i = 32'h8000_0500;
    tick();
    idle();
    chk("t3_conf_hit",    {31'd0, pred_hit_o}, 32'd1);
    chk("t3_conf_target", pred_target_o,       32'h8000_0500);
    lookup(32'h8000_0010);
    chk("t3_evicted_hit", {31'd0, pred_hit_o}, 32'd0);

    // T4 flush wins over update; lookup in flush cycle misses
    update(32'h8000_0010, 32'h8000_0200);
    lookup(32'h8000_0010);
    chk("t4_pre_hit", {31'd0, pred_hit_o}, 32'd1);
    flush_i         = 1'b1;
    update_i        = 1'b1;
    update_pc_i     = 32'h8000_0014;
    update_target_i = 32'h8000_0600;
    lookup_req_i    = 1'b1;
    lookup_pc_i     = 32'h8000_0010;
    tick();
    idle();
    chk("t4_flush_cycle_hit", {31'd0, pred_hit_o}, 32'd0);
    lookup(32'h8000_0010);
    chk("t4_idx4_hit", {31'd0, pred_hit_o}, 32'd0);
    lookup(32'h8000_0014);
    chk("t4_idx5_hit", {31'd0, pred_hit_o}, 32'd0);
    lookup(32'h8000_0020);
    chk("t4_idx8_hit", {31'd0, pred_hit_o}, 32'd0);

    // T5 reset mid-stream, coincident update dropped
    update(32'h8000_0010, 32'h8000_0200);
    lookup(32'h8000_0010);
    chk("t5_pre_hit", {31'd0, pred_hit_o}, 32'd1);
    rst             = 1'b1;
    lookup_req_i    = 1'b1;
    lookup_pc_i     = 32'h8000_0010;
    update_i        = 1'b1;
    update_pc_i     = 32'h8000_0014;
    update_target_i = 32'h8000_0700;
    tick();
    rst = 1'b0;
    idle();
    chk("t5_rst_valid",  {31'd0, pred_valid_o}, 32'd0);
    chk("t5_rst_hit",    {31'd0, pred_hit_o},   32'd0);
    chk("t5_rst_pc",     pred_pc_o,             32'd0);
    chk("t5_rst_target", pred_target_o,         32'd0);
    lookup(32'h8000_0010);
    chk("t5_post_hit", {31'd0, pred_hit_o}, 32'd0);
    lookup(32'h8000_0014);
    chk("t5_dropped_upd_hit", {31'd0, pred_hit_o}, 32'd0);

    // T6 hysteresis (or plain overwrite without it)
    update(32'h8000_0030, 32'h0000_1000);
    update(32'h8000_0030, 32'h0000_1000);
    update(32'h8000_0030, 32'h0000_2000);
    lookup(32'h8000_0030);
    chk("t6_first_b_hit",    {31'd0, pred_hit_o}, 32'd1);
    chk("t6_first_b_target", pred_target_o,       exp_t6);
    update(32'h8000_0030, 32'h0000_2000);
    update(32'h8000_0030, 32'h0000_2000);
    lookup(32'h8000_0030);
    chk("t6_third_b_target", pred_target_o, 32'h0000_2000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
